dcache_wr_buffer: RTL and testbench
===================================

# dcache_wr_buffer

Write buffer between the dcache and the SRAM-AXI bridge's write port. It accepts dirty-line evictions (4 words) and uncached stores (1 word) from the dcache into a small in-order FIFO. It drains them to the bridge using the bridge's single-cycle-request protocol, enforcing a minimum gap between issues. It also gives the dcache a line-address hazard check, so a read miss cannot overtake a buffered write to the same line.

## Interface
Parameters:
- DEPTH, 2, number of entries; power of 2, ≥2.
- ISSUE_GAP, 2, idle cycles forced on out_wr_req after each issue.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_wr_req  in  1  dcache write request.
- in_wr_type  in  3  3'b100 = line, other = uncached word/half/byte.
- in_wr_addr  in  32  write address.
- in_wr_wstrb  in  4  byte strobes.
- in_wr_data  in  128  line data; word 0 is in [31:0].
- in_wr_rdy  out  1  entry free; a push occurs when in_wr_req && in_wr_rdy.
- out_wr_req  out  1  single-cycle issue pulse to the bridge.
- out_wr_type  out  3  head entry type.
- out_wr_addr  out  32  head entry address.
- out_wr_wstrb  out  4  head entry strobes.
- out_wr_data  out  128  head entry data.
- out_wr_rdy  in  1  bridge ready.
- chk_addr  in  32  dcache read-miss or uncached-read address.
- chk_hit  out  1  combinational; a buffered entry matches chk_addr[31:4].
- empty  out  1  no valid entries.
- count  out  $clog2(DEPTH)+1  valid entries.

## Operation
- Storage: circular FIFO with wr_ptr and rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH. count tracks occupancy. Each entry holds {type, addr, wstrb, data}.
- Push: when in_wr_req && in_wr_rdy, write the entry at wr_ptr, then increment wr_ptr and count.
- in_wr_rdy = (count != DEPTH). There is no full-time pass-through: a push is refused while full, even in a pop cycle.
- Issue FSM, states IDLE / GAP:
  - IDLE: out_wr_req = !empty && out_wr_rdy. When it asserts, pop the head (increment rd_ptr, decrement count), load gap_cnt = ISSUE_GAP, and go to GAP.
  - GAP: out_wr_req = 0. Decrement gap_cnt each cycle; go to IDLE when it reaches 0. If ISSUE_GAP = 0, stay in IDLE.
- out_wr_* data fields always show the head entry (rd_ptr). Values are don't-care when empty. The bridge samples them in the issue cycle.
- Order: strict FIFO. Uncached and line writes are never reordered.
- Simultaneous push and pop: both take effect and count is unchanged.
- chk_hit: OR over valid entries of (entry.addr[31:4] == chk_addr[31:4]). The head entry counts until the cycle after it is popped. No data forwarding; the dcache stalls while chk_hit = 1.
- Reset mid-operation: all entries are discarded, with no issue for them.

## Timing
- Reset values:
  - Ports: in_wr_rdy = 1, out_wr_req = 0, empty = 1, count = 0, chk_hit = 0.
  - Internal: state IDLE, pointers 0, gap_cnt 0.
- Push-to-issue latency: entry pushed at cycle t gives earliest out_wr_req at t+1.
- Issue spacing: with a continuously ready bridge, consecutive out_wr_req pulses are exactly ISSUE_GAP+1 cycles apart.
- out_wr_req depends combinationally on out_wr_rdy and is never asserted two consecutive cycles.
- count, empty and in_wr_rdy update in the cycle after a push or pop edge. chk_hit is combinational on chk_addr plus registered state.

## Test plan
- Reset then idle: in_wr_rdy = 1, empty = 1, out_wr_req never asserts over 20 cycles.
- Single line write:
  - Stimulus: push addr 0x1C001230, type 4, data {w3..w0} = {4,3,2,1}, out_wr_rdy = 1.
  - Response: out_wr_req pulses one cycle at t+1 with out_wr_addr = 0x1C001230 and out_wr_data[31:0] = 1; then empty = 1.
- Full back-pressure (DEPTH = 2, out_wr_rdy = 0):
  - Push 3 requests: the third is held with in_wr_rdy = 0 and count = 2.
  - Raise out_wr_rdy: pops are spaced 3 cycles apart. The third push is accepted the cycle after the first pop. Issue order is 1, 2, 3.
- Mixed order: push line A, uncached word B (type 2, wstrb 4'b0011), line C. Issues occur in order A, B, C with out_wr_type 4, 2, 4.
- Hazard:
  - Stimulus: buffer line 0x80000040, then drive chk_addr 0x8000004C, then 0x80000050.
  - Response: chk_hit = 1 for 0x8000004C and 0 for 0x80000050. chk_hit for 0x8000004C drops the cycle after the entry issues.
- Reset with 2 entries buffered: count = 0 and no out_wr_req afterward. A new push after reset issues normally.

Source files
------------

// File: rtl/dcache_wr_buffer.sv
// dcache write buffer: in-order FIFO of line evictions and uncached stores,
// drained to the bridge with single-cycle issue pulses spaced by ISSUE_GAP
// idle cycles, plus a line-address hazard check for dcache read misses.
module dcache_wr_buffer #(
    parameter int DEPTH     = 2,
    parameter int ISSUE_GAP = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_wr_req,
    input  logic [2:0]               in_wr_type,
    input  logic [31:0]              in_wr_addr,
    input  logic [3:0]               in_wr_wstrb,
    input  logic [127:0]             in_wr_data,
    output logic                     in_wr_rdy,
    output logic                     out_wr_req,
    output logic [2:0]               out_wr_type,
    output logic [31:0]              out_wr_addr,
    output logic [3:0]               out_wr_wstrb,
    output logic [127:0]             out_wr_data,
    input  logic                     out_wr_rdy,
    input  logic [31:0]              chk_addr,
    output logic                     chk_hit,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = $clog2(ISSUE_GAP + 2);

    typedef struct packed {
        logic [2:0]   typ;
        logic [31:0]  addr;
        logic [3:0]   wstrb;
        logic [127:0] data;
    } entry_t;

    typedef enum logic {IDLE, GAP} state_t;

    entry_t           mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    state_t           state_q;
    logic [GW-1:0]    gap_q;

    logic push, pop;

    // No pass-through when full: a pop cycle does not free a slot for a same-cycle push.
    assign in_wr_rdy  = (count_q != CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign out_wr_req = (state_q == IDLE) && !empty && out_wr_rdy;
    assign push       = in_wr_req && in_wr_rdy;
    assign pop        = out_wr_req;

    assign out_wr_type  = mem_q[rd_ptr_q].typ;
    assign out_wr_addr  = mem_q[rd_ptr_q].addr;
    assign out_wr_wstrb = mem_q[rd_ptr_q].wstrb;
    assign out_wr_data  = mem_q[rd_ptr_q].data;

    // Hazard: any still-buffered entry on the same 16-byte line as chk_addr.
    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (mem_q[i].addr[31:4] == chk_addr[31:4])) chk_hit = 1'b1;
        end
    end

    // FIFO storage, pointers, per-slot valid bits and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{typ: in_wr_type, addr: in_wr_addr,
                                     wstrb: in_wr_wstrb, data: in_wr_data};
                vld_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Issue FSM: after each issue hold off ISSUE_GAP cycles before the next.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gap_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (out_wr_req && (ISSUE_GAP != 0)) begin
                        state_q <= GAP;
                        gap_q   <= GW'(ISSUE_GAP);
                    end
                end
                GAP: begin
                    gap_q <= gap_q - 1'b1;
                    if (gap_q == GW'(1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_wr_buffer.sv
// Bench for dcache_wr_buffer: directed pushes feed an expected-issue queue,
// an independent monitor checks every out_wr_req pulse against it.
module tb_dcache_wr_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_wr_req;
    logic [2:0]   in_wr_type;
    logic [31:0]  in_wr_addr;
    logic [3:0]   in_wr_wstrb;
    logic [127:0] in_wr_data;
    logic         in_wr_rdy;
    logic         out_wr_req;
    logic [2:0]   out_wr_type;
    logic [31:0]  out_wr_addr;
    logic [3:0]   out_wr_wstrb;
    logic [127:0] out_wr_data;
    logic         out_wr_rdy;
    logic [31:0]  chk_addr;
    logic         chk_hit;
    logic         empty;
    logic [1:0]   count;

    typedef struct {
        logic [2:0]   typ;
        logic [31:0]  addr;
        logic [3:0]   wstrb;
        logic [127:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   iss_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_iss = 0;
    logic prev_req = 1'b0;

    dcache_wr_buffer #(.DEPTH(2), .ISSUE_GAP(2)) dut (
        .clk(clk), .reset(reset),
        .in_wr_req(in_wr_req), .in_wr_type(in_wr_type), .in_wr_addr(in_wr_addr),
        .in_wr_wstrb(in_wr_wstrb), .in_wr_data(in_wr_data), .in_wr_rdy(in_wr_rdy),
        .out_wr_req(out_wr_req), .out_wr_type(out_wr_type), .out_wr_addr(out_wr_addr),
        .out_wr_wstrb(out_wr_wstrb), .out_wr_data(out_wr_data), .out_wr_rdy(out_wr_rdy),
        .chk_addr(chk_addr), .chk_hit(chk_hit), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every issue pulse must match the oldest outstanding push.
    always @(negedge clk) begin
        if (!reset && out_wr_req) begin
            n_iss++;
            iss_cyc.push_back(cyc);
            chk("no_back_to_back", prev_req, 1'b0);
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_type",  out_wr_type,  e.typ);
                chk("out_addr",  out_wr_addr,  e.addr);
                chk("out_wstrb", out_wr_wstrb, e.wstrb);
                chk("out_data",  out_wr_data,  e.data);
            end
        end
        prev_req = out_wr_req;
    end

    task automatic do_push(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                           input logic [127:0] d, output int acc);
        int n;
        exp_t e;
        n = 0;
        acc = -1;
        in_wr_req = 1'b1; in_wr_type = t; in_wr_addr = a; in_wr_wstrb = s; in_wr_data = d;
        while (acc < 0) begin
            @(negedge clk);
            if (in_wr_rdy) begin
                acc = cyc;
                e = '{typ: t, addr: a, wstrb: s, data: d};
                exp_q.push_back(e);
            end else if (++n > 50) begin
                chk("push_timeout", 1'b1, 1'b0);
                break;
            end
        end
        @(posedge clk); #1;
        in_wr_req = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && empty) && n < 100);
        if (n >= 100) chk("drain_timeout", 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    int acc, acc3;

    initial begin
        reset = 1'b1; in_wr_req = 1'b0; in_wr_type = '0; in_wr_addr = '0;
        in_wr_wstrb = '0; in_wr_data = '0; out_wr_rdy = 1'b1; chk_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state, then 20 idle cycles with no issue (monitor flags any).
        @(negedge clk);
        chk("rst_in_wr_rdy", in_wr_rdy, 1'b1);
        chk("rst_empty", empty, 1'b1);
        chk("rst_count", count, 2'd0);
        chk("rst_out_wr_req", out_wr_req, 1'b0);
        chk("rst_chk_hit", chk_hit, 1'b0);
        repeat (20) @(posedge clk);
        #1;

        // Single line write: issue in the cycle right after the push.
        iss_cyc.delete();
        do_push(3'b100, 32'h1C00_1230, 4'hF, {32'd4, 32'd3, 32'd2, 32'd1}, acc);
        wait_drain();
        chk("single_issue_count", iss_cyc.size(), 1);
        if (iss_cyc.size() >= 1) chk("single_latency", iss_cyc[0], acc + 1);
        chk("single_empty_after", empty, 1'b1);

        // Back-pressure: third push held while full, then accepted after first pop.
        out_wr_rdy = 1'b0;
        iss_cyc.delete();
        do_push(3'b100, 32'h0000_1000, 4'hF, 128'h11, acc);
        do_push(3'b100, 32'h0000_2000, 4'hF, 128'h22, acc);
        fork
            do_push(3'b100, 32'h0000_3000, 4'hF, 128'h33, acc3);
            begin
                repeat (2) @(negedge clk);
                chk("full_in_wr_rdy", in_wr_rdy, 1'b0);
                chk("full_count", count, 2'd2);
                @(posedge clk); #1;
                out_wr_rdy = 1'b1;
            end
        join
        wait_drain();
        chk("bp_issue_count", iss_cyc.size(), 3);
        if (iss_cyc.size() == 3) begin
            chk("bp_gap_1_2", iss_cyc[1] - iss_cyc[0], 3);
            chk("bp_gap_2_3", iss_cyc[2] - iss_cyc[1], 3);
            chk("bp_third_accept", acc3, iss_cyc[0] + 1);
        end

        // Mixed line / uncached order (types checked by the monitor).
        do_push(3'b100, 32'h0000_4000, 4'hF, 128'hAAAA, acc);
        do_push(3'b010, 32'h0000_5004, 4'b0011, 128'hBBBB, acc);
        do_push(3'b100, 32'h0000_6000, 4'hF, 128'hCCCC, acc);
        wait_drain();

        // Hazard check on line address, dropping the cycle after issue.
        out_wr_rdy = 1'b0;
        do_push(3'b100, 32'h8000_0040, 4'hF, 128'h5A5A, acc);
        chk_addr = 32'h8000_004C;
        @(negedge clk);
        chk("hazard_same_line", chk_hit, 1'b1);
        chk_addr = 32'h8000_0050;
        #1 chk("hazard_next_line", chk_hit, 1'b0);
        chk_addr = 32'h8000_004C;
        @(posedge clk); #1;
        out_wr_rdy = 1'b1;
        @(negedge clk);
        chk("hazard_issue_cycle_req", out_wr_req, 1'b1);
        chk("hazard_issue_cycle_hit", chk_hit, 1'b1);
        @(negedge clk);
        chk("hazard_after_issue", chk_hit, 1'b0);
        wait_drain();

        // Reset with two entries buffered: discarded, then normal operation.
        out_wr_rdy = 1'b0;
        do_push(3'b100, 32'h0000_7000, 4'hF, 128'h77, acc);
        do_push(3'b100, 32'h0000_8000, 4'hF, 128'h88, acc);
        @(negedge clk);
        chk("pre_reset_count", count, 2'd2);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_count", count, 2'd0);
        chk("post_reset_empty", empty, 1'b1);
        chk("post_reset_chk_hit", chk_hit, 1'b0);
        out_wr_rdy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        do_push(3'b100, 32'h0000_9000, 4'hF, 128'h99, acc);
        wait_drain();
        chk("final_count", count, 2'd0);
        chk("total_issues", n_iss, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
